// File: rtl/regfile_writeback_pkg.sv
// Shared types and widths for the regfile write-back front end.
//   DATA_WIDTH    : result width written into register_file (mirrors defs.vh `DATA_WIDTH)
//   REG_IDX_WIDTH : register index width (mirrors defs.vh `REG_IDX_WIDTH)
//   wb_entry_t    : one queued write {rd, data}
//   rr_t          : round-robin preference between the load and ALU sources
package regfile_writeback_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int REG_IDX_WIDTH = 5;

  typedef logic [REG_IDX_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  typedef struct packed {
    reg_idx_t rd;
    data_t    data;
  } wb_entry_t;

  typedef enum logic {
    RR_MEM = 1'b0,
    RR_ALU = 1'b1
  } rr_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bus bundle between execute/memory producers, decode and regfile_writeback.
//   alu_*/mem_* : valid/ready result handshakes (rd, data)
//   wr/rd/wd    : register_file write port
//   rs1/rs2     : decode source indices; pend_rs1/pend_rs2 hazard flags
//   count       : queue occupancy
// slave is the write-back block; master is the surrounding pipeline.
interface regfile_writeback_if
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic                     alu_ready;
  reg_idx_t                 alu_rd;
  data_t                    alu_data;
  logic                     mem_valid;
  logic                     mem_ready;
  reg_idx_t                 mem_rd;
  data_t                    mem_data;
  logic                     wr;
  reg_idx_t                 rd;
  data_t                    wd;
  reg_idx_t                 rs1;
  reg_idx_t                 rs2;
  logic                     pend_rs1;
  logic                     pend_rs2;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  rs1, rs2,
    output alu_ready, mem_ready,
    output wr, rd, wd,
    output pend_rs1, pend_rs2, count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output rs1, rs2,
    input  alu_ready, mem_ready,
    input  wr, rd, wd,
    input  pend_rs1, pend_rs2, count
  );
endinterface

// File: rtl/regfile_writeback_wb_queue.sv
// wb_queue: DEPTH-entry synchronous FIFO of pending register writes.
//   clk, rst_n   : clock, synchronous active-low reset (control state only)
//   i_push       : write i_entry at the tail (ignored when full)
//   i_pop        : drop the head entry (ignored when empty)
//   o_count      : occupied entries
//   o_head       : head entry, valid while o_count != 0
//   o_ent_vld    : per-slot occupied flag
//   o_ent_rd     : per-slot destination index, meaningful where o_ent_vld is set
module wb_queue
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  wb_entry_t                 i_entry,
  input  logic                      i_pop,
  output logic [$clog2(DEPTH):0]    o_count,
  output wb_entry_t                 o_head,
  output logic [DEPTH-1:0]          o_ent_vld,
  output reg_idx_t [DEPTH-1:0]      o_ent_rd
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]   r_vld;

  logic               w_do_push;
  logic               w_do_pop;
  logic [DEPTH-1:0]   w_vld_nxt;

  // Full check uses start-of-cycle occupancy: a same-cycle pop does not make room.
  assign w_do_push = i_push && (r_count < CNT_W'(DEPTH));
  assign w_do_pop  = i_pop  && (r_count != '0);

  // Payload storage carries no reset; occupancy is tracked by r_vld/r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_entry;
  end

  // Pop is cleared before push is set; they can only share a slot when the
  // queue is empty (no pop) or full (no push), so the order never matters.
  always_comb begin
    w_vld_nxt = r_vld;
    if (w_do_pop)  w_vld_nxt[r_rptr] = 1'b0;
    if (w_do_push) w_vld_nxt[r_wptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) o_ent_rd[i] = r_mem[i].rd;
  end

  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign o_ent_vld = r_vld;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: collects ALU and load results, queues them and drives
// register_file at one write per cycle, with pending-write hazard flags for decode.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; discards every queued write
//   bus   : regfile_writeback_if.slave (producer handshakes, register_file
//           write port, rs1/rs2 hazard lookup, occupancy count)
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_writeback_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  rr_t                  r_rr;

  logic [CNT_W-1:0]     w_count;
  wb_entry_t            w_head;
  logic [DEPTH-1:0]     w_ent_vld;
  reg_idx_t [DEPTH-1:0] w_ent_rd;

  logic                 w_not_full;
  logic                 w_grant_alu;
  logic                 w_grant_mem;
  logic                 w_alu_ready;
  logic                 w_mem_ready;
  logic                 w_alu_fire;
  logic                 w_mem_fire;
  logic                 w_contested;
  wb_entry_t            w_push_entry;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_wr;
  logic                 w_pend_rs1;
  logic                 w_pend_rs2;

  // A source loses its grant only when the other source is also valid and
  // currently preferred, so an idle bus shows both readies high.
  assign w_not_full  = w_count < CNT_W'(DEPTH);
  assign w_grant_alu = !bus.mem_valid || (r_rr == RR_ALU);
  assign w_grant_mem = !bus.alu_valid || (r_rr == RR_MEM);

  // Readies drop during reset so no producer sees a handshake that reset discards.
  assign w_alu_ready = rst_n && w_grant_alu && w_not_full;
  assign w_mem_ready = rst_n && w_grant_mem && w_not_full;
  assign w_alu_fire  = bus.alu_valid && w_alu_ready;
  assign w_mem_fire  = bus.mem_valid && w_mem_ready;
  assign w_contested = bus.alu_valid && bus.mem_valid && (w_alu_fire || w_mem_fire);

  assign w_push_entry = w_mem_fire ? '{rd: bus.mem_rd, data: bus.mem_data}
                                   : '{rd: bus.alu_rd, data: bus.alu_data};
  // x0 results complete the handshake but are never stored.
  assign w_push = (w_alu_fire || w_mem_fire) && (w_push_entry.rd != '0);
  // register_file always accepts, so the head retires whenever it exists.
  assign w_pop  = w_count != '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr <= RR_MEM;
    end else if (w_contested) begin
      r_rr <= (r_rr == RR_MEM) ? RR_ALU : RR_MEM;
    end
  end

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_wb_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_entry   (w_push_entry),
    .i_pop     (w_pop),
    .o_count   (w_count),
    .o_head    (w_head),
    .o_ent_vld (w_ent_vld),
    .o_ent_rd  (w_ent_rd)
  );

  // The head retiring this cycle is still occupied, so it still flags a hazard.
  always_comb begin
    w_pend_rs1 = 1'b0;
    w_pend_rs2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_rd[i] == bus.rs1)) w_pend_rs1 = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i] == bus.rs2)) w_pend_rs2 = 1'b1;
    end
    if (bus.rs1 == '0) w_pend_rs1 = 1'b0;
    if (bus.rs2 == '0) w_pend_rs2 = 1'b0;
  end

  // The write is suppressed during reset so a discarded head never lands.
  assign w_wr = rst_n && w_pop;

  assign bus.alu_ready = w_alu_ready;
  assign bus.mem_ready = w_mem_ready;
  assign bus.wr        = w_wr;
  assign bus.rd        = w_wr ? w_head.rd   : '0;
  assign bus.wd        = w_wr ? w_head.data : '0;
  assign bus.pend_rs1  = w_pend_rs1;
  assign bus.pend_rs2  = w_pend_rs2;
  assign bus.count     = w_count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: table of per-cycle vectors with
// hand-computed outputs, plus directed streaming and reset sequences.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  logic clk;
  logic rst_n;

  regfile_writeback_if #(.DEPTH(4)) bus ();

  regfile_writeback #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        ea;  logic       em;
    logic        ewr; logic [4:0] erd; logic [31:0] ewd;
    logic [2:0]  ecnt;
    logic        ep1; logic       ep2;
  } vec_t;

  vec_t vecs [15];

  int n_pass = 0;
  int n_tot  = 0;

  logic [4:0]  log_rd [$];
  logic [31:0] log_wd [$];
  logic [31:0] xreg   [32];

  // register_file model: a write presented now lands at the next rising edge.
  always @(negedge clk) begin
    if (bus.wr) begin
      log_rd.push_back(bus.rd);
      log_wd.push_back(bus.wd);
      xreg[bus.rd] = bus.wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input int n,
                           input logic [4:0] erd [6], input logic [31:0] ewd [6]);
    chk({tag, " nwrites"}, 32'(log_rd.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log_rd.size()) begin
        chk($sformatf("%s w%0d rd", tag, i), 32'(log_rd[i]), 32'(erd[i]));
        chk($sformatf("%s w%0d wd", tag, i), log_wd[i], ewd[i]);
      end
    end
    log_rd.delete();
    log_wd.delete();
  endtask

  initial begin
    logic [4:0]  exp_rd [6];
    logic [31:0] exp_wd [6];
    int k;
    int cyc;

    for (int i = 0; i < 32; i++) xreg[i] = '0;

    //             av ard ad   mv mrd md   rs1 rs2 ea em wr rd wd  cnt p1 p2
    vecs[0]  = '{0, 0, 0,  0, 0, 0,  0, 0,  1, 1, 0, 0, 0,  0, 0, 0};
    vecs[1]  = '{1, 1, 15, 0, 0, 0,  1, 0,  1, 1, 0, 0, 0,  0, 0, 0};
    vecs[2]  = '{0, 0, 0,  0, 0, 0,  1, 0,  1, 1, 1, 1, 15, 1, 1, 0};
    vecs[3]  = '{0, 0, 0,  0, 0, 0,  1, 0,  1, 1, 0, 0, 0,  0, 0, 0};
    vecs[4]  = '{1, 2, 5,  1, 5, 7,  5, 2,  0, 1, 0, 0, 0,  0, 0, 0};
    vecs[5]  = '{1, 2, 5,  1, 6, 8,  5, 2,  1, 0, 1, 5, 7,  1, 1, 0};
    vecs[6]  = '{0, 0, 0,  1, 6, 8,  5, 2,  0, 1, 1, 2, 5,  1, 0, 1};
    vecs[7]  = '{0, 0, 0,  0, 0, 0,  6, 0,  1, 1, 1, 6, 8,  1, 1, 0};
    vecs[8]  = '{0, 0, 0,  0, 0, 0,  0, 0,  1, 1, 0, 0, 0,  0, 0, 0};
    vecs[9]  = '{1, 0, 99, 0, 0, 0,  0, 0,  1, 1, 0, 0, 0,  0, 0, 0};
    vecs[10] = '{0, 0, 0,  0, 0, 0,  0, 0,  1, 1, 0, 0, 0,  0, 0, 0};
    vecs[11] = '{0, 0, 0,  1, 3, 10, 3, 0,  0, 1, 0, 0, 0,  0, 0, 0};
    vecs[12] = '{1, 3, 20, 0, 0, 0,  3, 0,  1, 1, 1, 3, 10, 1, 1, 0};
    vecs[13] = '{0, 0, 0,  0, 0, 0,  3, 0,  1, 1, 1, 3, 20, 1, 1, 0};
    vecs[14] = '{0, 0, 0,  0, 0, 0,  3, 0,  1, 1, 0, 0, 0,  0, 0, 0};

    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Table: one vector per cycle, outputs checked mid-cycle.
    for (int i = 0; i < 15; i++) begin
      bus.alu_valid = vecs[i].av; bus.alu_rd = vecs[i].ard; bus.alu_data = vecs[i].ad;
      bus.mem_valid = vecs[i].mv; bus.mem_rd = vecs[i].mrd; bus.mem_data = vecs[i].md;
      bus.rs1 = vecs[i].rs1; bus.rs2 = vecs[i].rs2;
      @(negedge clk);
      chk($sformatf("v%0d alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].ea));
      chk($sformatf("v%0d mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].em));
      chk($sformatf("v%0d wr", i),        32'(bus.wr),        32'(vecs[i].ewr));
      chk($sformatf("v%0d rd", i),        32'(bus.rd),        32'(vecs[i].erd));
      chk($sformatf("v%0d wd", i),        bus.wd,             vecs[i].ewd);
      chk($sformatf("v%0d count", i),     32'(bus.count),     32'(vecs[i].ecnt));
      chk($sformatf("v%0d pend_rs1", i),  32'(bus.pend_rs1),  32'(vecs[i].ep1));
      chk($sformatf("v%0d pend_rs2", i),  32'(bus.pend_rs2),  32'(vecs[i].ep2));
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    exp_rd = '{1, 5, 2, 6, 3, 3};
    exp_wd = '{15, 7, 5, 8, 10, 20};
    check_log("table", 6, exp_rd, exp_wd);
    chk("x1 final", xreg[1], 32'd15);
    chk("x3 final", xreg[3], 32'd20);
    chk("x0 untouched", xreg[0], 32'd0);

    // Streaming loads rd=1..6, one offered per cycle while the queue drains.
    k = 1;
    cyc = 0;
    while (k <= 6 && cyc < 20) begin
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(k);
      bus.mem_data  = 32'(100 + k);
      @(negedge clk);
      chk($sformatf("stream mem_ready c%0d", cyc), 32'(bus.mem_ready), 32'd1);
      chk($sformatf("stream count<=4 c%0d", cyc), 32'(bus.count <= 3'd4), 32'd1);
      if (bus.mem_ready) k++;
      next_cycle();
      cyc++;
    end
    idle_inputs();
    chk("stream accepted all", 32'(k), 32'd7);
    cyc = 0;
    while (bus.count != '0 && cyc < 10) begin
      next_cycle();
      cyc++;
    end
    next_cycle();
    chk("stream drained", 32'(bus.count), 32'd0);
    exp_rd = '{1, 2, 3, 4, 5, 6};
    exp_wd = '{101, 102, 103, 104, 105, 106};
    check_log("stream", 6, exp_rd, exp_wd);

    // Reset while a write is queued and another result is offered.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'd70;
    bus.rs1 = 5'd7;
    @(negedge clk);
    chk("rst pre alu_ready", 32'(bus.alu_ready), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    bus.alu_rd = 5'd9; bus.alu_data = 32'd90;
    bus.rs2 = 5'd9;
    @(negedge clk);
    chk("rst cycle wr", 32'(bus.wr), 32'd0);
    chk("rst cycle alu_ready", 32'(bus.alu_ready), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    chk("post rst count", 32'(bus.count), 32'd0);
    chk("post rst wr", 32'(bus.wr), 32'd0);
    chk("post rst pend_rs1", 32'(bus.pend_rs1), 32'd0);
    chk("post rst pend_rs2", 32'(bus.pend_rs2), 32'd0);
    chk("post rst alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("post rst mem_ready", 32'(bus.mem_ready), 32'd1);
    next_cycle();
    next_cycle();
    chk("post rst no writes", 32'(log_rd.size()), 32'd0);
    chk("x7 never written", xreg[7], 32'd0);
    chk("x9 never written", xreg[9], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
